// File: rtl/fetch_unit_if.sv
// Bundle of the two handshakes around the fetch stage:
//   imem_*  : request/grant/response port towards instruction memory
//   instr_* : valid/ready port towards decode
// Modports:
//   master : the fetch unit (drives requests and the decode-side head entry)
//   slave  : memory and decode environment
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding data_path.
// Holds the fetch PC, issues one word request at a time to instruction
// memory, buffers returned words with their PC in a circular prefetch FIFO
// and presents the FIFO head to decode. Taken branches/jumps redirect the PC
// and flush buffered and in-flight work; a misaligned target raises a sticky
// fault and halts fetching until reset.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bus (fetch_unit_if.master) imem req/gnt/rvalid port and decode valid/ready port
//   beq, bneq, bge, blt, jump  taken-redirect flags from data_path
//   target_pc                  redirect target
//   fetch_fault, fault_pc      sticky misaligned-target fault and offending target
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       bus,
  input  logic               beq,
  input  logic               bneq,
  input  logic               bge,
  input  logic               blt,
  input  logic               jump,
  input  logic [31:0]        target_pc,
  output logic               fetch_fault,
  output logic [31:0]        fault_pc
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_t;

  state_t        state;
  // PCs are kept as word addresses so the emitted address is aligned by construction.
  logic [31:2]   pc_fetch;
  logic [31:2]   pc_issued;
  // Low for the first cycle after reset so no request is raised in that cycle.
  logic          started;

  logic [31:0]   fifo_instr [DEPTH];
  logic [31:2]   fifo_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic redirect;
  logic aligned;
  logic fifo_nonempty;
  logic req;
  logic push;
  logic pop;

  assign redirect      = beq | bneq | bge | blt | jump;
  assign aligned       = (target_pc[1:0] == 2'b00);
  assign fifo_nonempty = (count != '0);

  // A pending request is withdrawn while a redirect is presented.
  assign req  = ~rst & started & (state == S_ISSUE) & (count < FULL) & ~redirect;
  // A response racing a redirect is discarded; a flush beats a dequeue.
  assign push = ~rst & (state == S_WAIT) & bus.imem_rvalid & ~redirect;
  assign pop  = ~rst & fifo_nonempty & bus.instr_ready & ~redirect;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = {pc_fetch, 2'b00};
  assign bus.instr_valid = ~rst & fifo_nonempty;
  assign bus.instr       = fifo_instr[rd_ptr];
  assign bus.instr_pc    = {fifo_pc[rd_ptr], 2'b00};

  // FIFO storage needs no reset: entries are only observable when count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]    <= pc_issued;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ISSUE;
      pc_fetch    <= RESET_PC[31:2];
      pc_issued   <= RESET_PC[31:2];
      started     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else begin
      started <= 1'b1;
      if (redirect && (state != S_HALT)) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        if (aligned) begin
          pc_fetch <= target_pc[31:2];
          case (state)
            S_ISSUE: state <= S_ISSUE;
            // The outstanding response must still be absorbed unless it is here now.
            S_WAIT,
            S_DROP:  state <= bus.imem_rvalid ? S_ISSUE : S_DROP;
            default: state <= S_HALT;
          endcase
        end else begin
          fetch_fault <= 1'b1;
          fault_pc    <= target_pc;
          state       <= S_HALT;
        end
      end else begin
        case (state)
          S_ISSUE: begin
            if (req && bus.imem_gnt) begin
              pc_issued <= pc_fetch;
              pc_fetch  <= pc_fetch + 1'b1;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.imem_rvalid) state <= S_ISSUE;
          end
          S_DROP: begin
            if (bus.imem_rvalid) state <= S_ISSUE;
          end
          S_HALT: begin
            state <= S_HALT;
          end
          default: state <= S_HALT;
        endcase

        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        beq, bneq, bge, blt, jump;
  logic [31:0] target_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .beq         (beq),
    .bneq        (bneq),
    .bge         (bge),
    .blt         (blt),
    .jump        (jump),
    .target_pc   (target_pc),
    .fetch_fault (fetch_fault),
    .fault_pc    (fault_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard of {instr, pc} expected at the decode port, plus memory model state.
  logic [63:0] sb[$];
  bit          pend;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  bit          warm;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic clear_inputs();
    beq = 0; bneq = 0; bge = 0; blt = 0; jump = 0;
    target_pc = '0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
    bus.instr_ready = 0;
  endtask

  task automatic model_reset();
    sb.delete();
    pend   = 0;
    exp_pc = RST_PC;
    warm   = 0;
  endtask

  task automatic apply_reset();
    rst = 1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  // Runs n cycles against the scoreboard; entered and left at posedge+1.
  task automatic test_stream(input string name, input int n, input int rdy_mode,
                             input int gnt_mode, input int rv_mode, output int grants);
    grants = 0;
    for (int c = 0; c < n; c++) begin
      bit g, rv, rd, exp_req, exp_val;
      logic [63:0] e;
      g  = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rv = pend && ((rv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      rd = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.imem_gnt    = g;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? ins_of(pend_addr) : 32'hDEAD_BEEF;
      bus.instr_ready = rd;
      #1;
      exp_req = warm && !pend && (sb.size() < DEPTH);
      exp_val = (sb.size() != 0);
      n_checks++;
      if (bus.imem_req !== exp_req)
        $display("FAIL %s_req c%0d: got %b want %b", name, c, bus.imem_req, exp_req);
      else n_pass++;
      if (exp_req) begin
        n_checks++;
        if (bus.imem_addr !== exp_pc)
          $display("FAIL %s_addr c%0d: got %h want %h", name, c, bus.imem_addr, exp_pc);
        else n_pass++;
      end
      n_checks++;
      if (bus.instr_valid !== exp_val)
        $display("FAIL %s_valid c%0d: got %b want %b", name, c, bus.instr_valid, exp_val);
      else n_pass++;
      if (exp_val) begin
        e = sb[0];
        n_checks++;
        if (bus.instr !== e[63:32] || bus.instr_pc !== e[31:0])
          $display("FAIL %s_head c%0d: got %h@%h want %h@%h", name, c,
                   bus.instr, bus.instr_pc, e[63:32], e[31:0]);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (exp_val && rd) void'(sb.pop_front());
      if (rv) begin
        sb.push_back({ins_of(pend_addr), pend_addr});
        pend = 0;
      end else if (exp_req && g) begin
        pend      = 1;
        pend_addr = exp_pc;
        exp_pc    = exp_pc + 32'd4;
        grants++;
      end
      warm = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    @(posedge clk); #1;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
      $display("FAIL reset_out: got req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid);
    else n_pass++;
    n_checks++;
    if (fetch_fault !== 1'b0 || fault_pc !== 32'h0)
      $display("FAIL reset_fault: got %b/%h want 0/0", fetch_fault, fault_pc);
    else n_pass++;
    rst = 0;
    model_reset();
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0)
      $display("FAIL reset_first_cycle_req: got %b want 0", bus.imem_req);
    else n_pass++;
    @(posedge clk); #1;
    warm = 1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
      $display("FAIL reset_first_req: got %b@%h want 1@%h", bus.imem_req, bus.imem_addr, RST_PC);
    else n_pass++;
  endtask

  task automatic test_full();
    int g;
    apply_reset();
    test_stream("full", 14, 0, 0, 0, g);
    n_checks++;
    if (g !== DEPTH) $display("FAIL full_grants: got %0d want %0d", g, DEPTH);
    else n_pass++;
    test_stream("pulse", 1, 1, 0, 0, g);
    bus.instr_ready = 0;
    bus.imem_gnt    = 0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10)
      $display("FAIL full_refill_req: got %b@%h want 1@00000010", bus.imem_req, bus.imem_addr);
    else n_pass++;
    @(posedge clk); #1;
    test_stream("refill", 6, 0, 0, 0, g);
    n_checks++;
    if (g !== 1) $display("FAIL full_refill_grants: got %0d want 1", g);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int g;
    apply_reset();
    test_stream("pre_rw", 6, 1, 0, 0, g);
    bus.imem_gnt = 1; bus.imem_rvalid = 0; bus.instr_ready = 1;
    beq = 1; target_pc = 32'h100;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0) $display("FAIL rw_wait_req: got %b want 0", bus.imem_req);
    else n_pass++;
    @(posedge clk); #1;
    beq = 0; target_pc = '0;
    bus.imem_rvalid = 1; bus.imem_rdata = ins_of(32'h8);
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
      $display("FAIL rw_drop: got req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid);
    else n_pass++;
    @(posedge clk); #1;
    bus.imem_rvalid = 0;
    sb.delete(); pend = 0; exp_pc = 32'h100;
    #1;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h100)
      $display("FAIL rw_target: got valid=%b addr=%h want 0/00000100",
               bus.instr_valid, bus.imem_addr);
    else n_pass++;
    test_stream("post_rw", 10, 1, 0, 0, g);
  endtask

  task automatic test_jump_flush();
    int g;
    apply_reset();
    test_stream("pre_jf", 6, 0, 0, 0, g);
    bus.imem_gnt = 1; bus.imem_rvalid = 1; bus.imem_rdata = ins_of(32'h8);
    bus.instr_ready = 1; jump = 1; target_pc = 32'h40;
    #1;
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0)
      $display("FAIL jf_before: got valid=%b pc=%h want 1/00000000", bus.instr_valid, bus.instr_pc);
    else n_pass++;
    @(posedge clk); #1;
    jump = 0; target_pc = '0; bus.imem_rvalid = 0;
    #1;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40)
      $display("FAIL jf_after: got valid=%b req=%b addr=%h want 0/1/00000040",
               bus.instr_valid, bus.imem_req, bus.imem_addr);
    else n_pass++;
    @(posedge clk); #1;
    sb.delete(); pend = 1; pend_addr = 32'h40; exp_pc = 32'h44;
    test_stream("post_jf", 12, 1, 0, 0, g);
  endtask

  task automatic test_fault();
    int g;
    apply_reset();
    test_stream("pre_f", 3, 1, 0, 0, g);
    bus.imem_gnt = 1; bus.instr_ready = 1; blt = 1; target_pc = 32'h102;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0) $display("FAIL fault_withdraw: got %b want 0", bus.imem_req);
    else n_pass++;
    @(posedge clk); #1;
    blt = 0; target_pc = '0;
    for (int i = 0; i < 8; i++) begin
      bus.imem_rvalid = 1; bus.imem_rdata = 32'h1234_5678;
      jump = (i == 3); target_pc = (i == 3) ? 32'h200 : 32'h0;
      #1;
      n_checks++;
      if (fetch_fault !== 1'b1 || fault_pc !== 32'h102)
        $display("FAIL fault_sticky c%0d: got %b/%h want 1/00000102", i, fetch_fault, fault_pc);
      else n_pass++;
      n_checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
        $display("FAIL fault_halt c%0d: got req=%b valid=%b want 0/0", i, bus.imem_req, bus.instr_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    apply_reset();
    #1;
    n_checks++;
    if (fetch_fault !== 1'b0 || fault_pc !== 32'h0)
      $display("FAIL fault_cleared: got %b/%h want 0/0", fetch_fault, fault_pc);
    else n_pass++;
    @(posedge clk); #1;
    warm = 1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
      $display("FAIL fault_restart: got %b@%h want 1@%h", bus.imem_req, bus.imem_addr, RST_PC);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int g;
    apply_reset();
    test_stream("pre_rm", 8, 0, 0, 0, g);
    rst = 1; bus.imem_rvalid = 0; bus.instr_ready = 0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
      $display("FAIL rm_during: got req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid);
    else n_pass++;
    @(posedge clk); #1;
    rst = 0; bus.imem_gnt = 1; bus.instr_ready = 1;
    bus.imem_rvalid = 1; bus.imem_rdata = ins_of(32'hC);
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0)
      $display("FAIL rm_after: got req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid);
    else n_pass++;
    @(posedge clk); #1;
    bus.imem_rvalid = 0;
    model_reset();
    warm = 1;
    #1;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC)
      $display("FAIL rm_late_rvalid: got valid=%b req=%b addr=%h want 0/1/%h",
               bus.instr_valid, bus.imem_req, bus.imem_addr, RST_PC);
    else n_pass++;
    test_stream("post_rm", 8, 1, 0, 0, g);
  endtask

  task automatic test_back_to_back();
    int g;
    apply_reset();
    test_stream("random", 300, 2, 1, 1, g);
    test_stream("drain", 20, 1, 0, 0, g);
  endtask

  initial begin
    int g;
    test_reset();
    test_stream("stream", 20, 1, 0, 0, g);
    test_full();
    test_redirect_wait();
    test_jump_flush();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
